// File: rtl/scircuit_pkg.sv
// Shared definitions for the scircuit pipelined datapath: default widths,
// shift-mode encodings and the shift-amount width helper.
package scircuit_pkg;

    localparam int DATAWIDTH_DEF = 32;
    localparam int CNTW_DEF      = 16;

    typedef enum int {
        SH_FLAG = 0,
        SH_OPND = 1
    } sh_mode_e;

    function automatic int shw(input int w);
        return $clog2(w);
    endfunction

endpackage

// File: rtl/pipe_stage_ctl.sv
// Valid bit and load enable for one elastic pipeline stage: the stage loads
// whenever it is empty or its downstream neighbour is loading this cycle.
module pipe_stage_ctl (
    input  logic clk,
    input  logic rst,
    input  logic i_up_valid,
    input  logic i_dn_load,
    output logic o_valid,
    output logic o_load,
    output logic o_capture
);

    logic r_valid;

    assign o_load    = !r_valid || i_dn_load;
    assign o_capture = o_load && i_up_valid;
    assign o_valid   = r_valid;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid <= 1'b0;
        end else if (o_load) begin
            r_valid <= i_up_valid;
        end
    end

endmodule

// File: rtl/scircuit_pipe.sv
// Three-stage signed datapath: add/add/sub, compare and double mux, then
// logical-left / arithmetic-right shift, with valid/ready flow control.
module scircuit_pipe
    import scircuit_pkg::*;
#(
    parameter int DATAWIDTH = DATAWIDTH_DEF,
    parameter int SHMODE    = int'(SH_FLAG),
    parameter int CNTW      = CNTW_DEF
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic signed [DATAWIDTH-1:0] a,
    input  logic signed [DATAWIDTH-1:0] b,
    input  logic signed [DATAWIDTH-1:0] c,
    input  logic                        in_valid,
    output logic                        in_ready,
    output logic signed [DATAWIDTH-1:0] x,
    output logic signed [DATAWIDTH-1:0] z,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [CNTW-1:0]             out_count
);

    localparam int SHW  = shw(DATAWIDTH);
    localparam bit OPND = (SHMODE == int'(SH_OPND));

    logic w_v1, w_v2, w_v3;
    logic w_ld1, w_ld2, w_ld3;
    logic w_cap1, w_cap2, w_cap3;

    pipe_stage_ctl u_s1 (
        .clk(clk), .rst(rst), .i_up_valid(in_valid), .i_dn_load(w_ld2),
        .o_valid(w_v1), .o_load(w_ld1), .o_capture(w_cap1)
    );
    pipe_stage_ctl u_s2 (
        .clk(clk), .rst(rst), .i_up_valid(w_v1), .i_dn_load(w_ld3),
        .o_valid(w_v2), .o_load(w_ld2), .o_capture(w_cap2)
    );
    pipe_stage_ctl u_s3 (
        .clk(clk), .rst(rst), .i_up_valid(w_v2), .i_dn_load(out_ready),
        .o_valid(w_v3), .o_load(w_ld3), .o_capture(w_cap3)
    );

    assign in_ready  = w_ld1;
    assign out_valid = w_v3;

    // Stage 1: sums and difference, wrapping modulo 2^DATAWIDTH.
    logic signed [DATAWIDTH-1:0] r_d, r_e, r_f;
    logic [SHW-1:0]              r_c1;

    // NOTE: data registers are reset too, so x/z read zero after reset rather than stale values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_d  <= '0;
            r_e  <= '0;
            r_f  <= '0;
            r_c1 <= '0;
        end else if (w_cap1) begin
            r_d  <= a + b;
            r_e  <= a + c;
            r_f  <= a - b;
            r_c1 <= c[SHW-1:0];
        end
    end

    // Stage 2: signed compare, double mux, shift-amount selection.
    logic                        w_lt, w_eq;
    logic signed [DATAWIDTH-1:0] w_g, w_h;
    logic [SHW-1:0]              w_shx, w_shz;
    logic signed [DATAWIDTH-1:0] r_g, r_h;
    logic [SHW-1:0]              r_shx, r_shz;

    assign w_lt  = (r_d < r_e);
    assign w_eq  = (r_d == r_e);
    assign w_g   = w_lt ? r_e : r_d;
    assign w_h   = w_eq ? r_f : w_g;
    assign w_shx = OPND ? r_c1 : SHW'(w_lt);
    assign w_shz = OPND ? r_c1 : SHW'(w_eq);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_g   <= '0;
            r_h   <= '0;
            r_shx <= '0;
            r_shz <= '0;
        end else if (w_cap2) begin
            r_g   <= w_g;
            r_h   <= w_h;
            r_shx <= w_shx;
            r_shz <= w_shz;
        end
    end

    // Stage 3: output registers hold while the consumer stalls.
    logic signed [DATAWIDTH-1:0] r_x, r_z;
    logic [CNTW-1:0]             r_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_x <= '0;
            r_z <= '0;
        end else if (w_cap3) begin
            r_x <= r_g << r_shx;
            r_z <= r_h >>> r_shz;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (w_v3 && out_ready) begin
            r_cnt <= r_cnt + CNTW'(1);
        end
    end

    assign x         = r_x;
    assign z         = r_z;
    assign out_count = r_cnt;

endmodule

// File: tb/tb_scircuit_pipe.sv
// Bench for scircuit_pipe: a transaction-level model checked every cycle
// against a 32-bit flag-shift instance, plus directed literal expectations.
module tb_scircuit_pipe;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Instance 0: DATAWIDTH=32, SHMODE=0, CNTW=16
    logic [31:0] a0, b0, c0, x0, z0;
    logic        iv0, rdy0, ov0, ordy0;
    logic [15:0] cnt0;

    // Instance 1: DATAWIDTH=32, SHMODE=1, CNTW=2
    logic [31:0] a1, b1, c1, x1, z1;
    logic        iv1, rdy1, ov1, ordy1;
    logic [1:0]  cnt1;

    scircuit_pipe #(.DATAWIDTH(32), .SHMODE(0), .CNTW(16)) dut0 (
        .clk(clk), .rst(rst), .a(a0), .b(b0), .c(c0),
        .in_valid(iv0), .in_ready(rdy0), .x(x0), .z(z0),
        .out_valid(ov0), .out_ready(ordy0), .out_count(cnt0)
    );

    scircuit_pipe #(.DATAWIDTH(32), .SHMODE(1), .CNTW(2)) dut1 (
        .clk(clk), .rst(rst), .a(a1), .b(b1), .c(c1),
        .in_valid(iv1), .in_ready(rdy1), .x(x1), .z(z1),
        .out_valid(ov1), .out_ready(ordy1), .out_count(cnt1)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Result of one transaction, straight from the arithmetic rules.
    function automatic void model(input int mode, input logic [31:0] a, input logic [31:0] b,
                                  input logic [31:0] c, output logic [31:0] x, output logic [31:0] z);
        logic signed [31:0] d, e, f, g, h;
        int sx, sz;
        d = a + b;
        e = a + c;
        f = a - b;
        g = (d < e) ? e : d;
        h = (d == e) ? f : g;
        if (mode == 0) begin
            sx = (d < e) ? 1 : 0;
            sz = (d == e) ? 1 : 0;
        end else begin
            sx = int'(c[4:0]);
            sz = int'(c[4:0]);
        end
        x = g << sx;
        z = h >>> sz;
    endfunction

    typedef struct {
        logic [31:0] x;
        logic [31:0] z;
        int          t;
    } txn_t;

    txn_t        q[$];
    logic [15:0] m_cnt = '0;
    int          cyc = 0;
    bit          saw_full = 1'b0;

    // Per-cycle comparison of instance 0 against the transaction model.
    always @(negedge clk) begin
        if (!rst) begin
            q.delete();
            m_cnt = '0;
        end else begin
            cyc++;
            check("in_ready", rdy0, (q.size() < 3) || ordy0);
            check("out_valid", ov0, (q.size() > 0) && (cyc - q[0].t >= 3));
            check("out_count", cnt0, m_cnt);
            if (!rdy0) saw_full = 1'b1;
            if (ov0 && ordy0 && q.size() > 0) begin
                check("x_stream", x0, q[0].x);
                check("z_stream", z0, q[0].z);
                void'(q.pop_front());
                m_cnt = m_cnt + 16'd1;
            end
            if (iv0 && rdy0) begin
                txn_t t;
                model(0, a0, b0, c0, t.x, t.z);
                t.t = cyc;
                q.push_back(t);
            end
        end
    end

    int hs1 = 0;
    always @(negedge clk) begin
        if (rst && ov1 && ordy1) hs1++;
    end

    task automatic align();
        @(posedge clk);
        #1;
    endtask

    // Called at posedge+1; returns at posedge+1 just after the accepting edge.
    task automatic push(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
        int guard;
        guard = 0;
        a0 = a; b0 = b; c0 = c; iv0 = 1'b1;
        @(negedge clk);
        while (!rdy0 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) check("push_timeout", 1, 0);
        @(posedge clk);
        #1;
        iv0 = 1'b0;
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!ov0 && lat < 20);
    endtask

    int lat;
    logic [31:0] va[8], vb[8], vc[8];

    initial begin
        rst = 1'b0;
        iv0 = 1'b0; ordy0 = 1'b1; a0 = '0; b0 = '0; c0 = '0;
        iv1 = 1'b0; ordy1 = 1'b1; a1 = '0; b1 = '0; c1 = '0;
        #1;
        check("rst_ov0", ov0, 0);
        check("rst_x0", x0, 0);
        check("rst_z0", z0, 0);
        check("rst_cnt0", cnt0, 0);
        check("rst_cnt1", cnt1, 0);
        #11 rst = 1'b1;
        align();

        // Vector 1
        push(32'd5, 32'd3, 32'd10);
        wait_out(lat);
        check("t1_lat", lat, 3);
        check("t1_x", x0, 32'd30);
        check("t1_z", z0, 32'd15);
        @(negedge clk);
        check("t1_cnt", cnt0, 1);
        align();

        // Vector 2: equal sums, arithmetic right shift of a negative value
        push(-32'sd4, 32'd2, 32'd2);
        wait_out(lat);
        check("t2_lat", lat, 3);
        check("t2_x", x0, 32'hFFFF_FFFE);
        check("t2_z", z0, 32'hFFFF_FFFD);
        align();

        // Vector 3: a+b wraps negative
        push(32'h7FFF_FFFF, 32'd1, 32'd0);
        wait_out(lat);
        check("t3_lat", lat, 3);
        check("t3_x", x0, 32'hFFFF_FFFE);
        check("t3_z", z0, 32'h7FFF_FFFF);
        align();

        // Back-to-back stream with a six-cycle consumer stall
        for (int i = 0; i < 8; i++) begin
            va[i] = 32'(i * 1013) - 32'd3000;
            vb[i] = 32'(i * 37 + 1);
            vc[i] = 32'(7 - 2 * i);
        end
        saw_full = 1'b0;
        fork
            begin
                for (int i = 0; i < 8; i++) push(va[i], vb[i], vc[i]);
            end
            begin
                repeat (3) @(posedge clk);
                #1 ordy0 = 1'b0;
                repeat (6) @(posedge clk);
                #1 ordy0 = 1'b1;
            end
        join
        for (int n = 0; n < 40 && q.size() != 0; n++) @(negedge clk);
        check("t4_drain", q.size(), 0);
        @(negedge clk);
        check("t4_cnt", cnt0, 11);
        check("t4_in_ready_dropped", saw_full, 1);
        align();

        // Asynchronous reset with all three stages occupied
        ordy0 = 1'b0;
        push(32'd100, 32'd1, 32'd1);
        push(32'd200, 32'd2, 32'd2);
        push(32'd300, 32'd3, 32'd3);
        #3 rst = 1'b0;
        #1;
        check("t5_x", x0, 0);
        check("t5_z", z0, 0);
        check("t5_ov", ov0, 0);
        check("t5_cnt", cnt0, 0);
        align();
        rst = 1'b1;
        ordy0 = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("t5_idle_ov", ov0, 0);
        end
        align();
        push(32'd6, 32'd1, 32'd2);
        wait_out(lat);
        check("t5_lat", lat, 3);
        check("t5_after_x", x0, 32'd16);
        check("t5_after_z", z0, 32'd8);
        @(negedge clk);
        check("t5_after_cnt", cnt0, 1);
        check("t5_after_ov", ov0, 0);
        align();

        // Operand shift mode, 2-bit wrapping counter
        a1 = 32'd1; b1 = 32'd1; c1 = 32'd4; iv1 = 1'b1;
        repeat (5) @(posedge clk);
        #1 iv1 = 1'b0;
        @(negedge clk);
        check("t6_ov", ov1, 1);
        check("t6_x", x1, 32'd80);
        check("t6_z", z1, 32'd0);
        repeat (6) @(negedge clk);
        check("t6_handoffs", hs1, 5);
        check("t6_cnt", cnt1, 1);
        check("t6_idle", ov1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
